cdc_handshake_tx: RTL and testbench

- Source-domain transmitter of a toggle-based four-phase-free (two-phase) req/ack clock-domain-crossing handshake for a multi-bit word.
- Accepts a word via valid/ready, holds it stable on data_out, toggles req_out, then waits for the destination's ack toggle, which is synchronized internally, before accepting the next word.
- Sits in the CImgProcCtrl control path wherever configuration or command words cross from the AXI/control clock into the image-processing clock.

---
 rtl/cimgproc_cdc_pkg.sv | 19 +
 rtl/sync_stages_n.sv | 27 ++
 rtl/cdc_handshake_tx.sv | 159 +++++++++++++++
 tb/tb_cdc_handshake_tx.sv | 249 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cimgproc_cdc_pkg.sv
// Shared definitions for the CImgProcCtrl toggle handshake CDC pair
// (transmitter here, matching receiver elsewhere): FSM state encoding
// and default synchronizer depth / watchdog limit.
package cimgproc_cdc_pkg;

    // Transmitter FSM state encoding.
    typedef enum logic [1:0] {
        HS_IDLE = 2'd0,
        HS_LOAD = 2'd1,
        HS_WAIT = 2'd2
    } hs_state_t;

    // Default number of synchronizer flops on the returning toggle.
    localparam int HS_SYNC_STAGES_DEFAULT    = 2;

    // Default WAIT_ACK watchdog limit, in source clock cycles.
    localparam int HS_TIMEOUT_CYCLES_DEFAULT = 1024;

endpackage : cimgproc_cdc_pkg

// File: rtl/sync_stages_n.sv
// Single-bit N-flop synchronizer with asynchronous active-low reset to 0.
// Used to bring the destination's ack toggle into the source clock domain.
module sync_stages_n
    import cimgproc_cdc_pkg::*;
#(
    parameter int N = HS_SYNC_STAGES_DEFAULT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic i_d,
    output logic o_q
);

    logic [N-1:0] r_sync;

    // Shift the asynchronous input through the flop chain.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[N-2:0], i_d};
        end
    end

    assign o_q = r_sync[N-1];

endmodule : sync_stages_n

// File: rtl/cdc_handshake_tx.sv
// Source-domain transmitter of a two-phase (toggle) req/ack CDC handshake
// for a multi-bit word. A word accepted on in_valid/in_ready is held on
// data_out, req_out toggles one cycle later, and the next word is only
// accepted once the synchronized ack toggle has caught up with req_out.
//
// Optional build macro: CDC_HS_TIMEOUT_EN adds a WAIT_ACK watchdog with a
// sticky timeout_err flag and its timeout_clr input.
//
// Upstream handshake: a word transfers on a rising clock edge where
// in_valid && in_ready. in_ready depends on registers only (never on
// in_valid). While in_ready is low, in_valid/in_data are ignored and the
// upstream must keep presenting its word until it is accepted.
module cdc_handshake_tx
    import cimgproc_cdc_pkg::*;
#(
    parameter int DATA_WIDTH     = 32,
    parameter int SYNC_STAGES    = HS_SYNC_STAGES_DEFAULT,
    parameter int TIMEOUT_CYCLES = HS_TIMEOUT_CYCLES_DEFAULT
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic [DATA_WIDTH-1:0] data_out,
    output logic                  req_out,
    input  logic                  ack_in,
    output logic                  busy,
`ifdef CDC_HS_TIMEOUT_EN
    output logic                  timeout_err,
    input  logic                  timeout_clr,
`endif
    output logic [1:0]            dbg_state
);

    // Reject illegal configurations at elaboration time.
    if (SYNC_STAGES < 2 || SYNC_STAGES > 4 || TIMEOUT_CYCLES < 1) begin : g_param_check
        $error("cdc_handshake_tx: SYNC_STAGES must be 2..4 and TIMEOUT_CYCLES >= 1");
    end

    hs_state_t             r_state;
    hs_state_t             w_state_next;
    logic [DATA_WIDTH-1:0] r_data_out;
    logic                  r_req_out;
    logic                  w_ack_sync;
    logic                  w_in_ready;
    logic                  w_load_data;
    logic                  w_toggle_req;

    sync_stages_n #(
        .N (SYNC_STAGES)
    ) u_ack_sync (
        .clock   (clock),
        .reset_n (reset_n),
        .i_d     (ack_in),
        .o_q     (w_ack_sync)
    );

    // Parity match means the destination has consumed the last request; a
    // mismatch in IDLE (spurious ack or one-sided reset) stalls intake.
    assign w_in_ready = (r_state == HS_IDLE) && (w_ack_sync == r_req_out);

    // FSM state register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= HS_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and datapath strobes.
    always_comb begin
        w_state_next = r_state;
        w_load_data  = 1'b0;
        w_toggle_req = 1'b0;
        case (r_state)
            HS_IDLE: begin
                if (in_valid && w_in_ready) begin
                    w_load_data  = 1'b1;
                    w_state_next = HS_LOAD;
                end
            end
            HS_LOAD: begin
                // Data has been stable for a cycle before the req edge.
                w_toggle_req = 1'b1;
                w_state_next = HS_WAIT;
            end
            HS_WAIT: begin
                if (w_ack_sync == r_req_out) begin
                    w_state_next = HS_IDLE;
                end
            end
            default: begin
                w_state_next = HS_IDLE;
            end
        endcase
    end

    // Word and request-toggle registers; both hold throughout WAIT_ACK.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_data_out <= '0;
            r_req_out  <= 1'b0;
        end else begin
            if (w_load_data) begin
                r_data_out <= in_data;
            end
            if (w_toggle_req) begin
                r_req_out <= ~r_req_out;
            end
        end
    end

`ifdef CDC_HS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] r_wd_cnt;
    logic             r_timeout_err;
    logic             w_timeout_hit;

    // The flag fires on the cycle the counter steps onto the limit, so a
    // wait that already timed out does not keep re-asserting it.
    assign w_timeout_hit = (r_state == HS_WAIT) && (r_wd_cnt != CNT_MAX)
                         && ((r_wd_cnt + 1'b1) == CNT_MAX);

    // Saturating WAIT_ACK cycle counter, cleared on entry to WAIT_ACK.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wd_cnt <= '0;
        end else if (r_state == HS_LOAD) begin
            r_wd_cnt <= '0;
        end else if ((r_state == HS_WAIT) && (r_wd_cnt != CNT_MAX)) begin
            r_wd_cnt <= r_wd_cnt + 1'b1;
        end
    end

    // Sticky timeout flag; a coincident new timeout beats the clear.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_timeout_err <= 1'b0;
        end else if (w_timeout_hit) begin
            r_timeout_err <= 1'b1;
        end else if (timeout_clr) begin
            r_timeout_err <= 1'b0;
        end
    end

    assign timeout_err = r_timeout_err;
`endif

    assign in_ready  = w_in_ready;
    assign data_out  = r_data_out;
    assign req_out   = r_req_out;
    assign busy      = (r_state != HS_IDLE);
    assign dbg_state = r_state;

endmodule : cdc_handshake_tx

// File: tb/tb_cdc_handshake_tx.sv
// Directed testbench for cdc_handshake_tx (DATA_WIDTH=32, SYNC_STAGES=2).
// Inputs change 1 ns after a rising edge; outputs are checked there too.
module tb_cdc_handshake_tx;
  import cimgproc_cdc_pkg::*;

  localparam int W = 32;

  // ---------------- clock / reset ----------------
  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_data = '0;
  logic [W-1:0] data_out;
  logic         req_out;
  logic         ack_in;
  logic         busy;
  logic [1:0]   dbg_state;
  logic         loop_en = 1'b1;
  logic         ack_man = 1'b0;
`ifdef CDC_HS_TIMEOUT_EN
  logic         timeout_err;
  logic         timeout_clr = 1'b0;
`endif

  // Destination model: either loops req straight back or holds a manual level.
  assign ack_in = loop_en ? req_out : ack_man;

  cdc_handshake_tx #(
    .DATA_WIDTH     (W),
    .SYNC_STAGES    (2),
    .TIMEOUT_CYCLES (16)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_data     (in_data),
    .data_out    (data_out),
    .req_out     (req_out),
    .ack_in      (ack_in),
    .busy        (busy),
`ifdef CDC_HS_TIMEOUT_EN
    .timeout_err (timeout_err),
    .timeout_clr (timeout_clr),
`endif
    .dbg_state   (dbg_state)
  );

  // ---------------- scoreboard ----------------
  int total = 0;
  int bad = 0;
  logic [W-1:0] exp_q[$];
  logic         exp_req = 1'b0;
  logic [W-1:0] exp_data = '0;

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Present one word and hold it until the edge that accepts it (caller
  // guarantees in_ready is already high).
  task automatic offer(input logic [W-1:0] word);
    in_valid = 1'b1;
    in_data  = word;
    exp_q.push_back(word);
    step();
    exp_data = exp_q.pop_front();
    in_valid = 1'b0;
    in_data  = 32'hFFFF_0000;
  endtask

  initial begin : hang_guard
    #200000;
    $display("FAIL hang_guard observed=timeout expected=finish");
    $fatal(1);
  end

  // ---------------- directed sequence ----------------
  initial begin : main
    // Reset held for 3 cycles.
    reset_n = 1'b0;
    step(); step(); step();
    check("rst_req",   W'(req_out), W'(1'b0));
    check("rst_data",  data_out, '0);
    check("rst_ready", W'(in_ready), W'(1'b1));
    check("rst_busy",  W'(busy), W'(1'b0));
    check("rst_state", W'(dbg_state), W'(HS_IDLE));
    reset_n = 1'b1;
    step();
    check("idle_ready", W'(in_ready), W'(1'b1));
    check("idle_busy",  W'(busy), W'(1'b0));

    // Single transfer with looped ack.
    loop_en = 1'b1;
    offer(32'hDEAD_BEEF);                      // E0
    check("t1_data_e0",  data_out, exp_data);
    check("t1_req_e0",   W'(req_out), W'(1'b0));
    check("t1_ready_e0", W'(in_ready), W'(1'b0));
    check("t1_state_e0", W'(dbg_state), W'(HS_LOAD));
    step();                                    // E1
    exp_req = ~exp_req;
    check("t1_req_e1",   W'(req_out), W'(exp_req));
    check("t1_ready_e1", W'(in_ready), W'(1'b0));
    step();                                    // E2
    check("t1_ready_e2", W'(in_ready), W'(1'b0));
    step();                                    // E3
    check("t1_ready_e3", W'(in_ready), W'(1'b0));
    check("t1_busy_e3",  W'(busy), W'(1'b1));
    step();                                    // E4
    check("t1_ready_e4", W'(in_ready), W'(1'b1));
    check("t1_busy_e4",  W'(busy), W'(1'b0));
    check("t1_data_e4",  data_out, 32'hDEAD_BEEF);

    // Back-to-back, in_valid held high, junk on in_data while not ready.
    in_valid = 1'b1;
    for (int k = 0; k < 3; k++) begin
      in_data = W'(k + 1);
      step();                                  // acceptance edge
      check("b2b_accept_data", data_out, W'(k + 1));
      check("b2b_accept_busy", W'(busy), W'(1'b1));
      in_data = 32'hBAD0_0000 + W'(k);
      if (k == 2) in_valid = 1'b0;
      for (int j = 1; j <= 4; j++) begin
        step();
        if (j == 1) exp_req = ~exp_req;
        check("b2b_hold_data", data_out, W'(k + 1));
        check("b2b_req",       W'(req_out), W'(exp_req));
        check("b2b_ready",     W'(in_ready), W'(j == 4));
      end
    end

    // Delayed ack: destination holds its old level for 50 cycles.
    loop_en = 1'b0;
    ack_man = exp_req;
    offer(32'h1234_5678);
    step();
    exp_req = ~exp_req;
    check("dly_req_toggle", W'(req_out), W'(exp_req));
    for (int i = 0; i < 50; i++) begin
      step();
      check("dly_busy",  W'(busy), W'(1'b1));
      check("dly_ready", W'(in_ready), W'(1'b0));
      check("dly_data",  data_out, exp_data);
      check("dly_req",   W'(req_out), W'(exp_req));
    end
    ack_man = exp_req;
    step();
    check("dly_ack_s1", W'(busy), W'(1'b1));
    step();
    check("dly_ack_s2", W'(busy), W'(1'b1));
    step();
    check("dly_ack_idle",  W'(busy), W'(1'b0));
    check("dly_ack_ready", W'(in_ready), W'(1'b1));

    // Spurious ack toggle while idle.
    ack_man = ~exp_req;
    step();
    check("spur_ready_1", W'(in_ready), W'(1'b1));
    step();
    check("spur_ready_2", W'(in_ready), W'(1'b0));
    in_valid = 1'b1;
    in_data  = 32'h0000_CAFE;
    for (int i = 0; i < 5; i++) begin
      step();
      check("spur_stall_ready", W'(in_ready), W'(1'b0));
      check("spur_stall_busy",  W'(busy), W'(1'b0));
      check("spur_stall_data",  data_out, 32'h1234_5678);
      check("spur_stall_req",   W'(req_out), W'(exp_req));
    end
    in_valid = 1'b0;
    ack_man  = exp_req;
    step();
    check("spur_recover_1", W'(in_ready), W'(1'b0));
    step();
    check("spur_recover_2", W'(in_ready), W'(1'b1));

    // Normal transfer after recovery, looped ack.
    loop_en = 1'b1;
    offer(32'hA5A5_5A5A);
    check("rec_data", data_out, exp_data);
    step();
    exp_req = ~exp_req;
    check("rec_req", W'(req_out), W'(exp_req));
    step(); step(); step();
    check("rec_ready", W'(in_ready), W'(1'b1));

    // Reset in the middle of a transfer drops the word.
    offer(32'h5555_AAAA);
    step();
    reset_n = 1'b0;
    #1;
    check("mid_rst_req",   W'(req_out), W'(1'b0));
    check("mid_rst_data",  data_out, '0);
    check("mid_rst_busy",  W'(busy), W'(1'b0));
    check("mid_rst_ready", W'(in_ready), W'(1'b1));
    step();
    reset_n = 1'b1;
    exp_req = 1'b0;
    step();
    check("post_rst_ready", W'(in_ready), W'(1'b1));

`ifdef CDC_HS_TIMEOUT_EN
    // Watchdog: ack withheld, limit 16 WAIT_ACK cycles.
    check("to_rst", W'(timeout_err), W'(1'b0));
    loop_en = 1'b0;
    ack_man = exp_req;
    offer(32'h0BAD_F00D);                      // E0
    step();                                    // E1, enter WAIT_ACK
    exp_req = ~exp_req;
    for (int i = 0; i < 15; i++) begin         // E2..E16
      step();
      check("to_before", W'(timeout_err), W'(1'b0));
    end
    step();                                    // E17
    check("to_set",      W'(timeout_err), W'(1'b1));
    check("to_busy",     W'(busy), W'(1'b1));
    step();
    check("to_sticky_w", W'(timeout_err), W'(1'b1));
    ack_man = exp_req;
    step(); step(); step();
    check("to_done_busy", W'(busy), W'(1'b0));
    check("to_sticky_i",  W'(timeout_err), W'(1'b1));
    timeout_clr = 1'b1;
    step();
    timeout_clr = 1'b0;
    check("to_clr", W'(timeout_err), W'(1'b0));
    step();
    check("to_clr_hold", W'(timeout_err), W'(1'b0));
`endif

    // ---------------- final report ----------------
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_cdc_handshake_tx
